// File: rtl/mem_responder.sv
// Memory-side responder: captures one MOV request, waits WAIT_STATES cycles, then performs
// a big-endian byte/halfword/word access on an internal byte array and holds MOC until MOV drops.
module mem_responder #(
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [1:0]  Size,
    input  logic        Signed,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic            rw_q;
    logic [31:0]     wdat_q;
    logic [1:0]      size_q;
    logic            sgn_q;
    logic [31:0]     dout_q, dout_d;
    logic            moc_q, moc_d;
    logic            err_q, err_d;

    logic [7:0]      mem [DEPTH];

    logic [AW-1:0]   idx [4];
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_data;
    logic            fault;
    logic [3:0]      lane_we;
    logic [7:0]      wb [4];
    logic            mem_we;
    logic            capture;

    wire unused_addr = &{1'b0, Address[31:AW]};

    assign capture = (state_q == S_IDLE) && MOV;

    // Lane k of the word containing the request is byte address base+k (big-endian: lane 0 = MSB).
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = {addr_q[AW-1:2], 2'(k)};
        end
        rd_word = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
        case (addr_q[1:0])
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = addr_q[1] ? rd_word[15:0] : rd_word[31:16];
    end

    always_comb begin
        fault   = 1'b0;
        rd_data = rd_word;
        lane_we = 4'b0000;
        wb[0]   = wdat_q[31:24];
        wb[1]   = wdat_q[23:16];
        wb[2]   = wdat_q[15:8];
        wb[3]   = wdat_q[7:0];
        case (size_q)
            2'b00: begin
                rd_data = {{24{sgn_q & rd_byte[7]}}, rd_byte};
                lane_we = 4'b0001 << addr_q[1:0];
                for (int k = 0; k < 4; k++) wb[k] = wdat_q[7:0];
            end
            2'b01: begin
                fault   = addr_q[0];
                rd_data = {{16{sgn_q & rd_half[15]}}, rd_half};
                lane_we = addr_q[1] ? 4'b1100 : 4'b0011;
                wb[0]   = wdat_q[15:8];
                wb[1]   = wdat_q[7:0];
                wb[2]   = wdat_q[15:8];
                wb[3]   = wdat_q[7:0];
            end
            2'b10: begin
                fault   = (addr_q[1:0] != 2'b00);
                lane_we = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
    end

    // WAIT_STATES=0 still passes through WAIT once so MOC always lands WAIT_STATES+1 edges after capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    moc_d   = 1'b1;
                    err_d   = fault;
                    dout_d  = (fault || !rw_q) ? 32'h0 : rd_data;
                    mem_we  = !fault && !rw_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            wdat_q  <= 32'h0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            dout_q  <= 32'h0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            if (capture) begin
                addr_q <= Address[AW-1:0];
                rw_q   <= RW;
                wdat_q <= DataIn;
                size_q <= Size;
                sgn_q  <= Signed;
            end
        end
    end

    // Array is deliberately outside the reset domain so its contents survive reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we && lane_we[k]) mem[idx[k]] <= wb[k];
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;
endmodule
